// File: rtl/counter_cmd_pkg.sv
// Shared definitions for the counter command sequencer: opcodes, FSM
// states, the FIFO entry layout and the opcode-to-strobe decode.
package counter_cmd_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_INC  = 3'd2;
    localparam logic [2:0] OP_DEC  = 3'd3;
    localparam logic [2:0] OP_SHL  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;

    localparam int ENTRY_W = 11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One queued command; packs to exactly ENTRY_W bits as {op, d, n}.
    typedef struct packed {
        logic [2:0] op;
        logic [3:0] d;
        logic [3:0] n;
    } cmd_t;

    // Strobe vector ordered {L, INC, DEC, SHL, SHR}; NOP and illegal give none.
    function automatic logic [4:0] opStrobes(input logic [2:0] op);
        logic [4:0] s;
        s = 5'b00000;
        case (op)
            OP_LOAD: s = 5'b10000;
            OP_INC:  s = 5'b01000;
            OP_DEC:  s = 5'b00100;
            OP_SHL:  s = 5'b00010;
            OP_SHR:  s = 5'b00001;
            default: s = 5'b00000;
        endcase
        return s;
    endfunction

    function automatic logic isLegalOp(input logic [2:0] op);
        return (op <= OP_SHR);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO. DEPTH must be a power of two so the
// read/write pointers wrap naturally; the occupancy count is one bit wider.
module cmd_fifo
    import counter_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     C,
    input  logic                     R,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ENTRY_W-1:0]       din,
    output logic [ENTRY_W-1:0]       dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wrPtr_q;
    logic [AW-1:0]      rdPtr_q;
    logic [AW:0]        count_q;
    logic               doPush;
    logic               doPop;

    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign dout   = mem_q[rdPtr_q];
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge C) begin
        if (doPush && !R) begin
            mem_q[wrPtr_q] <= din;
        end
    end

    // Pointers and occupancy, flushed by reset so a reset always empties the queue.
    always_ff @(posedge C) begin
        if (R) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Command sequencer in front of the 4-bit counter: pops queued commands and
// replays each one as a run of registered one-hot strobes, so the counter
// never sees two controls in the same cycle.
module counter_cmd_sequencer
    import counter_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       C,
    input  logic       R,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [2:0] CMD_OP,
    input  logic [3:0] CMD_D,
    input  logic [3:0] CMD_N,
    input  logic       HOLD,
    output logic       L,
    output logic       INC,
    output logic       DEC,
    output logic       SHL,
    output logic       SHR,
    output logic [3:0] D,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic               fifoFull;
    logic               fifoEmpty;
    logic [ENTRY_W-1:0] fifoDout;
    logic [CW-1:0]      fifoCount;
    logic               pushEn;
    logic               popEn;
    cmd_t               head;
    cmd_t               pushCmd;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [3:0] rem_q, rem_d;
    logic [3:0] dat_q, dat_d;
    logic [4:0] stb_q, stb_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic [3:0] nEff;

    assign pushEn    = CMD_VALID && !fifoFull;
    assign CMD_READY = !fifoFull;
    assign pushCmd   = '{op: CMD_OP, d: CMD_D, n: CMD_N};
    assign head      = cmd_t'(fifoDout);

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) uFifo (
        .C     (C),
        .R     (R),
        .push  (pushEn),
        .pop   (popEn),
        .din   (pushCmd),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    // Next-state decode: repeat the current strobe, pop the next command, or fall idle; HOLD freezes everything and blanks the strobes.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        dat_d   = dat_q;
        stb_d   = 5'b00000;
        done_d  = 1'b0;
        err_d   = 1'b0;
        popEn   = 1'b0;
        nEff    = 4'd0;
        if (!HOLD) begin
            if (state_q == ST_RUN && rem_q != 4'd0) begin
                rem_d  = rem_q - 4'd1;
                stb_d  = opStrobes(op_q);
                done_d = (rem_q == 4'd1);
            end else if (!fifoEmpty) begin
                popEn   = 1'b1;
                state_d = ST_RUN;
                op_d    = head.op;
                dat_d   = head.d;
                if (!isLegalOp(head.op)) begin
                    rem_d = 4'd0;
                    err_d = 1'b1;
                end else begin
                    nEff   = (head.op == OP_LOAD) ? 4'd0 : head.n;
                    rem_d  = nEff;
                    stb_d  = opStrobes(head.op);
                    done_d = (nEff == 4'd0);
                end
            end else begin
                state_d = ST_IDLE;
                rem_d   = 4'd0;
            end
        end
        busy_d = (state_d == ST_RUN) || pushEn || (fifoCount > CW'(popEn));
    end

    // Register the FSM, repeat counter and every output so the counter sees clean strobes.
    always_ff @(posedge C) begin
        if (R) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            rem_q   <= 4'd0;
            dat_q   <= 4'd0;
            stb_q   <= 5'b00000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            dat_q   <= dat_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign {L, INC, DEC, SHL, SHR} = stb_q;
    assign D    = dat_q;
    assign DONE = done_q;
    assign ERR  = err_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Self-checking bench for counter_cmd_sequencer: directed scenarios followed
// by a randomized run, all checked against a command-level reference model.
module tb_counter_cmd_sequencer;

    typedef struct {
        logic [4:0] stb;
        logic [3:0] d;
        logic       done;
        logic       err;
        int         cyc;
    } ev_t;

    logic       C = 1'b0;
    logic       R;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [2:0] CMD_OP;
    logic [3:0] CMD_D;
    logic [3:0] CMD_N;
    logic       HOLD;
    logic       L, INC, DEC, SHL, SHR;
    logic [3:0] D;
    logic       BUSY, DONE, ERR;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   oneHotViol = 0;
    int   obsIdx = 0;
    ev_t  obsQ[$];
    ev_t  expQ[$];
    logic [3:0] cntModel = 4'h0;
    logic [3:0] expCnt = 4'h0;

    counter_cmd_sequencer #(
        .DEPTH (4)
    ) dut (
        .C         (C),
        .R         (R),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_D     (CMD_D),
        .CMD_N     (CMD_N),
        .HOLD      (HOLD),
        .L         (L),
        .INC       (INC),
        .DEC       (DEC),
        .SHL       (SHL),
        .SHR       (SHR),
        .D         (D),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 C = ~C;

    // Downstream 4-bit counter fed by the strobes, plus a cycle index for gap checks.
    always @(posedge C) begin
        cyc <= cyc + 1;
        if (L)        cntModel <= D;
        else if (INC) cntModel <= cntModel + 4'd1;
        else if (DEC) cntModel <= cntModel - 4'd1;
        else if (SHL) cntModel <= {cntModel[2:0], D[0]};
        else if (SHR) cntModel <= {D[3], cntModel[3:1]};
    end

    // Log every cycle that carries a strobe, DONE or ERR, and flag illegal overlaps.
    always @(negedge C) begin
        if ($countones({L, INC, DEC, SHL, SHR}) > 1 || (DONE && ERR))
            oneHotViol <= oneHotViol + 1;
        if (L || INC || DEC || SHL || SHR || DONE || ERR)
            obsQ.push_back('{stb: {L, INC, DEC, SHL, SHR}, d: D, done: DONE, err: ERR, cyc: cyc});
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge C);
        #1;
    endtask

    function automatic logic [4:0] stbFor(input logic [2:0] op);
        case (op)
            3'd1:    return 5'b10000;
            3'd2:    return 5'b01000;
            3'd3:    return 5'b00100;
            3'd4:    return 5'b00010;
            3'd5:    return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    // Expected visible cycles of one command, and its effect on the counter value.
    function automatic void expandCmd(input logic [2:0] op, input logic [3:0] d, input logic [3:0] n);
        int reps;
        reps = (op == 3'd1) ? 1 : int'(n) + 1;
        if (op == 3'd0) begin
            expQ.push_back('{stb: 5'b0, d: d, done: 1'b1, err: 1'b0, cyc: 0});
        end else if (op > 3'd5) begin
            expQ.push_back('{stb: 5'b0, d: d, done: 1'b0, err: 1'b1, cyc: 0});
        end else begin
            for (int i = 0; i < reps; i++)
                expQ.push_back('{stb: stbFor(op), d: d, done: (i == reps - 1), err: 1'b0, cyc: 0});
            case (op)
                3'd1: expCnt = d;
                3'd2: expCnt = 4'(int'(expCnt) + reps);
                3'd3: expCnt = 4'(int'(expCnt) - reps);
                3'd4: for (int i = 0; i < reps; i++) expCnt = {expCnt[2:0], d[0]};
                default: for (int i = 0; i < reps; i++) expCnt = {d[3], expCnt[3:1]};
            endcase
        end
    endfunction

    function automatic logic [10:0] evKey(input ev_t e);
        return {e.stb, (e.stb != 5'b0) ? e.d : 4'h0, e.done, e.err};
    endfunction

    // Offer one command and wait (bounded) until it is accepted.
    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] d, input logic [3:0] n, input bit model);
        bit acc;
        acc = 1'b0;
        CMD_VALID = 1'b1;
        CMD_OP = op;
        CMD_D = d;
        CMD_N = n;
        for (int i = 0; i < 100; i++) begin
            acc = CMD_READY;
            step();
            if (acc) break;
        end
        CMD_VALID = 1'b0;
        if (!acc) checkOutput("push_accept", 32'(acc), 32'd1);
        else if (model) expandCmd(op, d, n);
    endtask

    task automatic waitIdle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!BUSY) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        checkOutput({tag, "_idle"}, 32'(ok), 32'd1);
        step();
    endtask

    task automatic compareEvents(input string tag);
        int nObs;
        nObs = obsQ.size() - obsIdx;
        checkOutput({tag, "_events"}, nObs, expQ.size());
        for (int i = 0; i < expQ.size() && i < nObs; i++)
            checkOutput($sformatf("%s_ev%0d", tag, i), 32'(evKey(obsQ[obsIdx + i])), 32'(evKey(expQ[i])));
        checkOutput({tag, "_counter"}, 32'(cntModel), 32'(expCnt));
        checkOutput({tag, "_onehot"}, oneHotViol, 0);
    endtask

    task automatic nextScenario();
        obsIdx = obsQ.size();
        expQ.delete();
    endtask

    initial begin
        bit acc;
        int base;
        R = 1'b1;
        CMD_VALID = 1'b0;
        CMD_OP = 3'd0;
        CMD_D = 4'h0;
        CMD_N = 4'h0;
        HOLD = 1'b0;
        repeat (3) step();
        checkOutput("rst_strobes", 32'({L, INC, DEC, SHL, SHR}), 32'd0);
        checkOutput("rst_d", 32'(D), 32'd0);
        checkOutput("rst_done_err", 32'({DONE, ERR}), 32'd0);
        checkOutput("rst_busy", 32'(BUSY), 32'd0);
        checkOutput("rst_ready", 32'(CMD_READY), 32'd1);
        R = 1'b0;
        step();
        nextScenario();

        $display("[TB] LOAD latency");
        applyStimulus(3'd1, 4'hA, 4'h5, 1'b1);
        checkOutput("load_lat_l", 32'(L), 32'd0);
        checkOutput("load_lat_busy", 32'(BUSY), 32'd1);
        step();
        checkOutput("load_l", 32'(L), 32'd1);
        checkOutput("load_d", 32'(D), 32'hA);
        checkOutput("load_done", 32'(DONE), 32'd1);
        step();
        checkOutput("load_l_off", 32'({L, DONE}), 32'd0);
        waitIdle("load");
        compareEvents("load");
        nextScenario();

        $display("[TB] back-to-back INC/DEC");
        applyStimulus(3'd1, 4'hF, 4'h0, 1'b1);
        applyStimulus(3'd2, 4'h3, 4'h2, 1'b1);
        applyStimulus(3'd3, 4'h5, 4'h0, 1'b1);
        waitIdle("incdec");
        compareEvents("incdec");
        checkOutput("incdec_value", 32'(cntModel), 32'h1);
        if (obsQ.size() - obsIdx >= 5)
            checkOutput("incdec_nogap", obsQ[obsIdx + 4].cyc - obsQ[obsIdx].cyc, 4);
        nextScenario();

        $display("[TB] fill under HOLD");
        HOLD = 1'b1;
        step();
        for (int i = 0; i < 4; i++) applyStimulus(3'd4, 4'b0001, 4'h0, 1'b1);
        checkOutput("fill_ready_low", 32'(CMD_READY), 32'd0);
        CMD_VALID = 1'b1;
        CMD_OP = 3'd4;
        CMD_D = 4'b0001;
        CMD_N = 4'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("fill_blocked%0d", i), 32'({CMD_READY, SHL}), 32'd0);
        end
        CMD_VALID = 1'b0;
        HOLD = 1'b0;
        step();
        checkOutput("fill_first_shl", 32'(SHL), 32'd1);
        checkOutput("fill_ready_up", 32'(CMD_READY), 32'd1);
        waitIdle("fill");
        compareEvents("fill");
        nextScenario();

        $display("[TB] illegal op and NOP");
        applyStimulus(3'd2, 4'h1, 4'h0, 1'b1);
        applyStimulus(3'd7, 4'h2, 4'h3, 1'b1);
        applyStimulus(3'd2, 4'h4, 4'h1, 1'b1);
        applyStimulus(3'd0, 4'h9, 4'h2, 1'b1);
        waitIdle("illegal");
        compareEvents("illegal");
        nextScenario();

        $display("[TB] HOLD mid-SHR");
        applyStimulus(3'd5, 4'h6, 4'h3, 1'b1);
        for (int i = 0; i < 20 && !SHR; i++) step();
        checkOutput("shr_s1", 32'(SHR), 32'd1);
        step();
        checkOutput("shr_s2", 32'(SHR), 32'd1);
        HOLD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("shr_held%0d", i), 32'(SHR), 32'd0);
        end
        HOLD = 1'b0;
        step();
        checkOutput("shr_s3", 32'({SHR, DONE}), 32'b10);
        step();
        checkOutput("shr_s4", 32'({SHR, DONE}), 32'b11);
        step();
        checkOutput("shr_after", 32'(SHR), 32'd0);
        waitIdle("shr");
        compareEvents("shr");
        if (obsQ.size() - obsIdx >= 4)
            checkOutput("shr_gap", obsQ[obsIdx + 2].cyc - obsQ[obsIdx + 1].cyc, 4);
        nextScenario();

        $display("[TB] reset mid-command");
        applyStimulus(3'd2, 4'h0, 4'h5, 1'b0);
        applyStimulus(3'd1, 4'h7, 4'h0, 1'b0);
        applyStimulus(3'd3, 4'h0, 4'h1, 1'b0);
        checkOutput("rstmid_inc_running", 32'(INC), 32'd1);
        R = 1'b1;
        CMD_VALID = 1'b1;
        CMD_OP = 3'd1;
        CMD_D = 4'h3;
        step();
        R = 1'b0;
        CMD_VALID = 1'b0;
        expCnt = expCnt + 4'd2;
        checkOutput("rstmid_outputs", 32'({L, INC, DEC, SHL, SHR, D, DONE, ERR}), 32'd0);
        checkOutput("rstmid_busy", 32'(BUSY), 32'd0);
        checkOutput("rstmid_ready", 32'(CMD_READY), 32'd1);
        nextScenario();
        repeat (12) step();
        checkOutput("rstmid_quiet_busy", 32'(BUSY), 32'd0);
        compareEvents("rstmid");
        nextScenario();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 200; i++) begin
            CMD_VALID = ($urandom_range(0, 2) != 0);
            CMD_OP = 3'($urandom_range(0, 7));
            CMD_D = 4'($urandom);
            CMD_N = 4'($urandom_range(0, 3));
            HOLD = ($urandom_range(0, 7) == 0);
            acc = CMD_VALID && CMD_READY;
            step();
            if (acc) expandCmd(CMD_OP, CMD_D, CMD_N);
        end
        CMD_VALID = 1'b0;
        HOLD = 1'b0;
        waitIdle("rand");
        base = expQ.size();
        $display("[TB] random commands expanded to %0d cycles", base);
        compareEvents("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
